// File: rtl/usb_crc5_token_tx.sv
// USB token transmit serializer: sends the 11-bit ADDR/ENDP field LSB-first,
// then the inverted CRC5 MSb-first, one bit per downstream shift_en strobe.
module usb_crc5_token_tx #(
  parameter int unsigned          FIELD_BITS = 11,
  parameter int unsigned          CRC_WIDTH  = 5,
  parameter logic [CRC_WIDTH-1:0] POLY       = 5'b00101,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT   = 5'b11111
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [FIELD_BITS-1:0] field_in,
  input  logic                  abort,
  input  logic                  shift_en,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned MAX_BITS = (FIELD_BITS > CRC_WIDTH) ? FIELD_BITS : CRC_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);
  localparam int unsigned SHR_W    = FIELD_BITS - 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FIELD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CRC_WIDTH-1:0] r_crc;
  logic [CNT_W-1:0]     r_cnt;
  logic [SHR_W-1:0]     r_shreg;
  logic                 r_tx_bit;
  logic                 r_tx_valid;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_fb;
  logic [CRC_WIDTH-1:0] w_crc_next;

  // Serial CRC update for the bit currently on the wire.
  always_comb begin
    w_fb       = r_tx_bit ^ r_crc[CRC_WIDTH-1];
    w_crc_next = {r_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end

  // Bit 0 of the field goes straight to tx_bit; r_shreg holds the remaining bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_crc      <= CRC_INIT;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_tx_bit   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_tx_bit   <= 1'b0;
        r_tx_valid <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state    <= S_DATA;
              r_shreg    <= field_in[FIELD_BITS-1:1];
              r_crc      <= CRC_INIT;
              r_cnt      <= '0;
              r_tx_bit   <= field_in[0];
              r_tx_valid <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          S_DATA: begin
            if (shift_en) begin
              r_crc   <= w_crc_next;
              r_shreg <= r_shreg >> 1;
              if (r_cnt == LAST_DATA) begin
                r_state  <= S_CRC;
                r_cnt    <= '0;
                r_tx_bit <= ~w_crc_next[CRC_WIDTH-1];
              end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_tx_bit <= r_shreg[0];
              end
            end
          end
          S_CRC: begin
            // The CRC is frozen here; shifting it left keeps the next bit at the MSb.
            if (shift_en) begin
              r_crc <= {r_crc[CRC_WIDTH-2:0], 1'b0};
              if (r_cnt == LAST_CRC) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_tx_bit   <= 1'b0;
                r_tx_valid <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_tx_bit <= ~r_crc[CRC_WIDTH-2];
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_bit   = r_tx_bit;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_usb_crc5_token_tx.sv
// Self-checking bench for usb_crc5_token_tx: table vectors, random fields with
// random shift_en duty against a serial CRC5 reference, plus abort/reset corners.
module tb_usb_crc5_token_tx;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [10:0] field_in;
  logic        abort;
  logic        shift_en;
  logic        tx_bit;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  localparam int BUDGET = 2000;

  usb_crc5_token_tx dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .field_in (field_in),
    .abort    (abort),
    .shift_en (shift_en),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] field;
    int          duty;
    bit          use_const;
    logic [15:0] exp_bits;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference serial CRC5 (x^5+x^2+1, seed all ones) over the first n bits of b.
  function automatic logic [4:0] crc5_ref(input logic [15:0] b, input int n);
    int r;
    int top;
    r = 31;
    for (int i = 0; i < n; i++) begin
      top = (r >> 4) & 1;
      r   = (r * 2) % 32;
      if ((top ^ int'(b[i])) == 1) r = r ^ 5;
    end
    return 5'(r);
  endfunction

  // Expected wire order: field LSB-first then inverted CRC MSb-first.
  function automatic logic [15:0] model_packet(input logic [10:0] f);
    logic [15:0] p;
    logic [4:0]  c;
    p       = '0;
    p[10:0] = f;
    c       = ~crc5_ref({5'b0, f}, 11);
    for (int k = 0; k < 5; k++) p[11 + k] = c[4 - k];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [10:0] f, input string tag);
    start    = 1'b1;
    field_in = f;
    step();
    start = 1'b0;
    check({tag, " kick busy"},  32'(busy), 32'd1);
    check({tag, " kick valid"}, 32'(tx_valid), 32'd1);
    check({tag, " kick bit0"},  32'(tx_bit), 32'(f[0]));
    check({tag, " kick done"},  32'(done), 32'd0);
  endtask

  // Consumes one packet; ends at the sample point of the done cycle.
  task automatic body(input logic [10:0] f, input int duty, input int start_at,
                      input string tag, output logic [15:0] got);
    logic [15:0] exp;
    int n, iters, busy_cnt;
    bit valid_ok, stall_ok, se;
    logic prev;
    exp = model_packet(f);
    got = '0;
    n = 0; iters = 0; busy_cnt = 0;
    valid_ok = 1'b1; stall_ok = 1'b1;
    while (n < 16 && iters < BUDGET) begin
      if (busy) busy_cnt++;
      if (!tx_valid) valid_ok = 1'b0;
      if (n == start_at) begin
        start    = 1'b1;
        field_in = ~f;
      end
      se = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      shift_en = se;
      prev = tx_bit;
      if (se) begin
        got[n] = tx_bit;
        n++;
      end
      step();
      start = 1'b0;
      if (!se && tx_bit !== prev) stall_ok = 1'b0;
      iters++;
    end
    shift_en = 1'b0;
    check({tag, " strobes"},  32'(n), 32'd16);
    check({tag, " bits"},     32'(got), 32'(exp));
    check({tag, " residual"}, 32'(crc5_ref(got, 16)), 32'h0C);
    check({tag, " valid"},    32'(valid_ok), 32'd1);
    check({tag, " stall"},    32'(stall_ok), 32'd1);
    check({tag, " busy cyc"}, 32'(busy_cnt), 32'(iters));
    if (duty >= 100) check({tag, " cycles"}, 32'(iters), 32'd16);
    check({tag, " done"},     32'(done), 32'd1);
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " vld end"},  32'(tx_valid), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(tx_valid), 32'd0);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " bit"},   32'(tx_bit), 32'd0);
  endtask

  vec_t        tbl[6];
  logic [15:0] got;
  logic [15:0] ref_pkt;
  logic [10:0] f;
  bit          no_done;

  initial begin
    n_rst = 1'b1; start = 1'b0; abort = 1'b0; shift_en = 1'b0; field_in = '0;

    tbl[0] = '{11'h000, 100, 1'b1, 16'h1000};
    tbl[1] = '{11'h000,  30, 1'b1, 16'h1000};
    tbl[2] = '{11'h715, 100, 1'b0, 16'h0000};
    tbl[3] = '{11'h715,  30, 1'b0, 16'h0000};
    tbl[4] = '{11'h7FF, 100, 1'b0, 16'h0000};
    tbl[5] = '{11'h555,  60, 1'b0, 16'h0000};

    // Asynchronous reset mid-cycle
    #2 n_rst = 1'b0;
    #1 check_idle("reset");
    step();
    step();
    n_rst = 1'b1;
    step();
    check_idle("post reset");

    for (int i = 0; i < 6; i++) begin
      kick(tbl[i].field, $sformatf("tbl%0d", i));
      body(tbl[i].field, tbl[i].duty, -1, $sformatf("tbl%0d", i), got);
      if (tbl[i].use_const) check($sformatf("tbl%0d const", i), 32'(got), 32'(tbl[i].exp_bits));
      step();
      check($sformatf("tbl%0d done pulse", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      f = 11'($urandom());
      kick(f, $sformatf("rnd%0d", i));
      body(f, (i % 3 == 0) ? 100 : 20 + int'($urandom_range(0, 60)), -1,
           $sformatf("rnd%0d", i), got);
      step();
      check($sformatf("rnd%0d done pulse", i), 32'(done), 32'd0);
    end

    // start while busy (at bit 6) must not disturb the packet
    kick(11'h715, "collide");
    body(11'h715, 100, 6, "collide", got);
    step();
    check("collide after", 32'(busy), 32'd0);

    // start on the done cycle, then stray shift_en three cycles after done
    kick(11'h2A5, "chainA");
    body(11'h2A5, 100, -1, "chainA", got);
    kick(11'h13C, "chainB");
    body(11'h13C, 30, -1, "chainB", got);
    step();
    step();
    step();
    shift_en = 1'b1;
    step();
    shift_en = 1'b0;
    check_idle("late strobe");
    step();
    check_idle("late strobe+1");

    // abort while presenting CRC bit 2, with start and shift_en also high
    f = 11'h3C9;
    ref_pkt = model_packet(f);
    kick(f, "abort");
    shift_en = 1'b1;
    repeat (13) step();
    shift_en = 1'b0;
    check("abort pre valid", 32'(tx_valid), 32'd1);
    check("abort pre bit",   32'(tx_bit), 32'(ref_pkt[13]));
    abort = 1'b1; start = 1'b1; field_in = 11'h7FF; shift_en = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; shift_en = 1'b0;
    check_idle("abort");
    no_done = 1'b1;
    repeat (4) begin
      step();
      if (done || busy) no_done = 1'b0;
    end
    check("abort quiet", 32'(no_done), 32'd1);
    kick(11'h7FF, "post abort");
    body(11'h7FF, 100, -1, "post abort", got);
    step();

    // reset pulsed during DATA
    kick(11'h0F0, "rst mid");
    shift_en = 1'b1;
    repeat (5) step();
    shift_en = 1'b0;
    #2 n_rst = 1'b0;
    #1 check_idle("rst mid");
    step();
    n_rst = 1'b1;
    step();
    check_idle("rst mid release");
    kick(11'h7FF, "post rst");
    body(11'h7FF, 40, -1, "post rst", got);
    step();
    check("post rst done pulse", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_crc5_token_tx.md
Name: usb_crc5_token_tx

Overview:
Transmit-side companion to the receive CRC5 checker. It takes the parallel 11-bit USB token field (7-bit ADDR, 4-bit ENDP), serializes it LSB-first, computes CRC5 on the fly, and appends the inverted CRC5 MSb-first. It sits between the token packet builder and the bit-stuffer/NRZI encoder, which paces it with a one-cycle bit-time strobe. A receive CRC5 checker fed the resulting 16 bits ends with the fixed good-packet residual.

Parameters:
FIELD_BITS, 11, number of token field bits serialized before the CRC.
CRC_WIDTH, 5, CRC register width.
POLY, 5'b00101, generator x^5+x^2+1 without the x^5 term.
CRC_INIT, 5'b11111, CRC register seed at start.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to send field_in; honoured only in IDLE.
field_in  input  11  {ENDP[3:0], ADDR[6:0]}; bit 0 is sent first.
abort  input  1  synchronous cancel; returns the block to IDLE.
shift_en  input  1  downstream consumed tx_bit this cycle; advance to the next bit.
tx_bit  output  1  current serial bit (registered).
tx_valid  output  1  tx_bit is meaningful; high in DATA and CRC states.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse after the last CRC bit is consumed.

Behaviour:
- Reset (async, n_rst=0): state IDLE; crc=CRC_INIT; bit counter 0; shift register 0; tx_bit=0; tx_valid=0; busy=0; done=0.
- States: IDLE, DATA, CRC. done is a registered pulse issued on the CRC->IDLE transition.
- IDLE + start=1:
  - latch field_in into the shift register; crc<=CRC_INIT; cnt<=0; go to DATA.
  - The next cycle has tx_valid=1, busy=1, tx_bit=field_in[0].
  - Latency from start to first valid bit: 1 cycle.
- DATA + shift_en=1:
  - fb = tx_bit ^ crc[4]; crc <= {crc[3:0],1'b0} ^ (fb ? POLY : 0); shift register right by 1; cnt++.
  - When cnt==FIELD_BITS-1 is consumed: go to CRC, cnt<=0, tx_bit<=~crc_next[4].
- CRC + shift_en=1:
  - Shift the frozen CRC left; tx_bit presents ~crc[4-cnt], giving the inverted CRC MSb-first; cnt++.
  - After the 5th bit is consumed: go to IDLE, tx_valid<=0, done<=1 for 1 cycle.
- shift_en=0: everything holds (tx_bit, crc, cnt unchanged). Stalls of any length are legal.
- shift_en in IDLE: ignored.
- start while busy: ignored; the in-flight field is unaffected.
- start in the same cycle as done: accepted, since the state is already IDLE. Back-to-back packets therefore have a 1-cycle IDLE gap.
- abort (any state): next cycle IDLE, tx_valid=0, busy=0, done not asserted.
  - abort has priority over shift_en and start in the same cycle.
- Reset mid-packet: immediate return to reset values; no done pulse.
- Throughput: exactly FIELD_BITS+CRC_WIDTH=16 shift_en strobes per packet; extra strobes beyond that land in IDLE and are ignored.

Test Plan:
- Reset values: assert n_rst=0 mid-cycle -> tx_valid=0, busy=0, done=0, tx_bit=0 immediately, without waiting for a clock edge.
- All-zero field: start with field_in=11'h000, shift_en held high -> 11 zeros, then CRC bits 0,1,0,0,0 (crc 5'b10111 inverted). done pulses 1 cycle after the 16th strobe. busy is high for exactly 16 cycles after the start cycle.
- Residual check: field_in={4'hE,7'h15} (and 20 random fields), all 16 bits fed into a reference serial CRC5 seeded 5'b11111 -> final register 5'b01100 in every case.
- Stall: same field with shift_en toggled randomly (about 30% duty) -> bit sequence identical to the no-stall run; tx_bit is stable across every cycle where shift_en=0.
- Collisions: start pulsed on bit 6 -> ignored, output unchanged. start on the done cycle -> new packet begins next cycle. shift_en asserted 3 cycles after done -> no effect.
- Abort/reset mid-op: abort at CRC bit 2 -> IDLE next cycle, no done. A following start with 11'h7FF produces a correct full packet. Repeat with n_rst pulsed low during DATA -> same recovery.
